// File: rtl/quadc_snap_capture_pkg.sv
// quadc_snap_capture_pkg: shared FSM state encoding, word packing order and buffer depth default.
package quadc_snap_capture_pkg;
  localparam int DEPTH_LOG2_DEF = 10;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;
  function automatic logic [31:0] pack_word(input logic [7:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction
endpackage

// File: rtl/quadc_snap_capture_if.sv
// quadc_snap_capture_if: ADC sample, capture control and readback signals of the snapshot block.
interface quadc_snap_capture_if import quadc_snap_capture_pkg::*; #(parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF);
  logic [7:0] adc0_data;
  logic [7:0] adc1_data;
  logic [7:0] adc2_data;
  logic [7:0] adc3_data;
  logic valid;
  logic sync;
  logic arm;
  logic trig_sel;
  logic busy;
  logic done;
  logic rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [31:0] rd_data;
  logic rd_valid;
  modport slave (
    input  adc0_data, adc1_data, adc2_data, adc3_data, valid, sync, arm, trig_sel, rd_en, rd_addr,
    output busy, done, rd_data, rd_valid
  );
  modport master (
    output adc0_data, adc1_data, adc2_data, adc3_data, valid, sync, arm, trig_sel, rd_en, rd_addr,
    input  busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/snap_bram_sdp.sv
// snap_bram_sdp: simple dual-port buffer, one write port and one registered read-first read port.
module snap_bram_sdp #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // only the output register is reset; storage keeps contents across captures
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/quadc_snap_capture.sv
// quadc_snap_capture: arms on request, triggers on first (sync-qualified) valid sample, fills the buffer once.
module quadc_snap_capture import quadc_snap_capture_pkg::*; #(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input logic adc0_clk,
  input logic reset,
  quadc_snap_capture_if.slave bus
);
  state_t                state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] waddr;
  logic                  trig;
  logic                  we;
  logic                  last;
  logic                  rd_valid;
  assign trig  = bus.valid && (!bus.trig_sel || bus.sync);
  assign we    = (state == ST_ARMED && trig) || (state == ST_CAPTURE && bus.valid);
  assign waddr = (state == ST_ARMED) ? '0 : wr_ptr;
  assign last  = &wr_ptr;
  assign bus.busy     = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign bus.done     = (state == ST_DONE);
  assign bus.rd_valid = rd_valid;
  always_ff @(posedge adc0_clk or posedge reset)
    if (reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.rd_en;
      case (state)
        ST_IDLE, ST_DONE: if (bus.arm) state <= ST_ARMED;
        ST_ARMED: if (trig) begin
          state  <= ST_CAPTURE;
          wr_ptr <= DEPTH_LOG2'(1);
        end
        ST_CAPTURE: if (bus.valid) begin
          // pointer parks on the last address instead of wrapping
          wr_ptr <= last ? wr_ptr : wr_ptr + 1'b1;
          if (last) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  snap_bram_sdp #(.AW(DEPTH_LOG2), .DW(32)) u_bram (
    .clk   (adc0_clk),
    .rst   (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (pack_word(bus.adc0_data, bus.adc1_data, bus.adc2_data, bus.adc3_data)),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );
endmodule
